instruction_fetch_unit: RTL

//  Upstream of main_control in KGP-RISC: holds the PC, fetches 32-bit words from instruction memory

---
 rtl/instruction_fetch_unit_pkg.sv | 16 +
 rtl/instruction_fetch_unit_pc_register.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared widths and fetch FSM encoding
package instruction_fetch_unit_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// rtl/instruction_fetch_unit_pc_register.sv - program counter with hold / +4 / redirect next-PC mux
module instruction_fetch_unit_pc_register #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  // Redirect is only honoured when the current instruction retires.
  always_comb begin
    pc_next = pc;
    if (advance) begin
      pc_next = redirect ? (redirect_target & ~ADDR_W'(3)) : (pc + ADDR_W'(4));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC-driven instruction fetch with req/valid memory handshake and timeout retry
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic                fetch_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t      state, next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              load_instr;
  logic              timeout_hit;
  logic              advance;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;

  instruction_fetch_unit_pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk             (clk),
    .rst             (rst),
    .advance         (advance),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_next         (pc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A response arriving on the last WAIT cycle takes priority over the retry.
  always_comb begin
    next_state  = state;
    load_instr  = 1'b0;
    timeout_hit = 1'b0;
    advance     = 1'b0;
    case (state)
      ST_IDLE: next_state = ST_REQ;
      ST_REQ:  next_state = ST_WAIT;
      ST_WAIT: begin
        if (imem_valid) begin
          load_instr = 1'b1;
          next_state = ST_HOLD;
        end else if (wait_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          next_state  = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          advance    = 1'b1;
          next_state = ST_REQ;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request strobe and address are registered from the next state so they line up with REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      wait_cnt    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_out      <= RESET_PC;
      pc_plus4    <= RESET_PC + ADDR_W'(4);
      fetch_err   <= 1'b0;
    end else begin
      imem_req <= (next_state == ST_REQ);
      if (next_state == ST_REQ) begin
        imem_addr <= pc_next;
      end
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (load_instr) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
        pc_out      <= pc;
        pc_plus4    <= pc + ADDR_W'(4);
      end else if (advance) begin
        instr_valid <= 1'b0;
      end
      if (timeout_hit) begin
        fetch_err <= 1'b1;
      end
    end
  end

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];

endmodule
